serial_seq_detector: RTL and testbench

//   Consumes the registered serial bit stream from the D flip-flop stage
//   (its Q output drives DIN here) and detects a fixed PAT_W-bit pattern.

---
 rtl/serial_seq_detector.sv | 98 +++++++++
 tb/tb_serial_seq_detector.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_seq_detector.sv
// Serial pattern detector: registered one-cycle match pulse plus a saturating match counter.
// Define SEQ_OVERLAP_EN to let overlapping occurrences of the pattern each count as a match.
module serial_seq_detector #(
  parameter int unsigned         PAT_W   = 4,
  parameter logic [PAT_W-1:0]    PATTERN = 4'b1011,
  parameter int unsigned         CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_vld,
  input  logic             clr,
  output logic             match,
  output logic [CNT_W-1:0] count,
  output logic             sat,
  output logic [1:0]       state
);

  localparam int unsigned       FillW    = $clog2(PAT_W + 1);
  localparam logic [FillW-1:0]  FillFull = FillW'(PAT_W);
  localparam logic [CNT_W-1:0]  CountMax = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFill  = 2'd1,
    StArmed = 2'd2
  } state_e;

  // Only the newest PAT_W-1 bits are stored; the oldest bit of a window is never needed again.
  logic [PAT_W-2:0] hist_q;
  logic [FillW-1:0] fill_q;
  state_e           state_q;
  logic             match_q;
  logic [CNT_W-1:0] count_q;
  logic             sat_q;

  logic [PAT_W-1:0] window;
  logic [FillW-1:0] fill_inc;
  logic [CNT_W-1:0] count_inc;
  logic             hit;

  always_comb begin
    window    = {hist_q, din};
    fill_inc  = (fill_q == FillFull) ? FillFull : fill_q + FillW'(1);
    count_inc = count_q + CNT_W'(1);
    // fill_inc reaching full means this bit completes a PAT_W-bit window
    hit       = din_vld && (fill_inc == FillFull) && (window == PATTERN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q  <= '0;
      fill_q  <= '0;
      state_q <= StIdle;
      match_q <= 1'b0;
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      match_q <= hit;

      if (din_vld) begin
        hist_q <= window[PAT_W-2:0];
        if (hit) begin
`ifdef SEQ_OVERLAP_EN
          fill_q  <= FillFull;
          state_q <= StArmed;
`else
          fill_q  <= '0;
          state_q <= StIdle;
`endif
        end else begin
          fill_q  <= fill_inc;
          state_q <= (fill_inc == FillFull) ? StArmed : StFill;
        end
      end

      if (clr) begin
        count_q <= '0;
        sat_q   <= 1'b0;
      end else if (hit) begin
        if (count_q == CountMax) begin
          sat_q <= 1'b1;
        end else begin
          count_q <= count_inc;
          if (count_inc == CountMax) begin
            sat_q <= 1'b1;
          end
        end
      end
    end
  end

  assign match = match_q;
  assign count = count_q;
  assign sat   = sat_q;
  assign state = state_q;

endmodule

// File: tb/tb_serial_seq_detector.sv
// Scoreboard bench: stimulus pushes the expected COUNT for each match; negedge monitors pop on MATCH.
module tb_serial_seq_detector;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       din_a = 1'b0, vld_a = 1'b0;
  logic       din_z = 1'b0, vld_z = 1'b0;
  logic       match_a, sat_a, match_z, sat_z;
  logic [7:0] count_a;
  logic [1:0] count_z;
  logic [1:0] state_a, state_z;

  int total = 0;
  int bad = 0;
  int q_a[$];
  int q_z[$];

  always #5 clk = ~clk;

  serial_seq_detector #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .din(din_a), .din_vld(vld_a), .clr(clr),
    .match(match_a), .count(count_a), .sat(sat_a), .state(state_a)
  );

  serial_seq_detector #(.PAT_W(4), .PATTERN(4'b0000), .CNT_W(2)) dut_z (
    .clk(clk), .rst_n(rst_n), .din(din_z), .din_vld(vld_z), .clr(clr),
    .match(match_z), .count(count_z), .sat(sat_z), .state(state_z)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitors: every MATCH pulse must correspond to a queued expectation.
  always @(negedge clk) begin
    if (rst_n && match_a) begin
      if (q_a.size() == 0) chk("a unexpected match", 1, 0);
      else chk("a count at match", int'(count_a), q_a.pop_front());
    end
    if (rst_n && match_z) begin
      if (q_z.size() == 0) chk("z unexpected match", 1, 0);
      else chk("z count at match", int'(count_z), q_z.pop_front());
    end
  end

  task automatic step_a(input logic v, input logic d, input logic c);
    vld_a = v; din_a = d; clr = c;
    @(posedge clk); #1;
    vld_a = 1'b0; clr = 1'b0;
  endtask

  task automatic step_z(input logic v, input logic d, input logic c);
    vld_z = v; din_z = d; clr = c;
    @(posedge clk); #1;
    vld_z = 1'b0; clr = 1'b0;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset();
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  initial begin
    int k;
    int zextra;
    int zper;
    logic [3:0] bits7;
`ifdef SEQ_OVERLAP_EN
    zextra = 3; zper = 1;
`else
    zextra = 12; zper = 4;
`endif

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset match", int'(match_a), 0);
    chk("reset count", int'(count_a), 0);
    chk("reset sat", int'(sat_a), 0);
    chk("reset state", int'(state_a), 0);

    // Zero pattern: the fill counter must hold off a match until the 4th bit.
    for (int i = 0; i < 3; i++) step_z(1'b1, 1'b0, 1'b0);
    chk("z count before fill", int'(count_z), 0);
    q_z.push_back(1);
    step_z(1'b1, 1'b0, 1'b0);
    step_z(1'b0, 1'b0, 1'b0);
    chk("z count after first", int'(count_z), 1);

    // Saturation with a 2-bit counter.
    k = 1;
    for (int i = 1; i <= zextra; i++) begin
      if (i % zper == 0) begin
        k++;
        q_z.push_back(k > 3 ? 3 : k);
      end
      step_z(1'b1, 1'b0, 1'b0);
    end
    chk("z count saturated", int'(count_z), 3);
    chk("z sat set", int'(sat_z), 1);
    step_z(1'b0, 1'b1, 1'b0);
    step_z(1'b0, 1'b0, 1'b0);
    chk("z count held", int'(count_z), 3);
    chk("z sat held", int'(sat_z), 1);
    step_z(1'b0, 1'b0, 1'b1);
    chk("z count cleared", int'(count_z), 0);
    chk("z sat cleared", int'(sat_z), 0);

    // Basic 1011 with state trace.
    pulse_reset();
    step_a(1'b1, 1'b1, 1'b0);
    chk("state after bit1", int'(state_a), 1);
    step_a(1'b1, 1'b0, 1'b0);
    chk("state after bit2", int'(state_a), 1);
    step_a(1'b1, 1'b1, 1'b0);
    chk("state after bit3", int'(state_a), 1);
    q_a.push_back(1);
    step_a(1'b1, 1'b1, 1'b0);
`ifdef SEQ_OVERLAP_EN
    chk("state after match", int'(state_a), 2);
`else
    chk("state after match", int'(state_a), 0);
`endif
    step_a(1'b0, 1'b0, 1'b0);
    step_a(1'b0, 1'b0, 1'b0);
    chk("count after 1011", int'(count_a), 1);

    // 1011011: overlap decides whether the second 1011 counts.
    pulse_reset();
    bits7 = 4'b0;
    for (int i = 0; i < 7; i++) begin
      if (i == 3) q_a.push_back(1);
`ifdef SEQ_OVERLAP_EN
      if (i == 6) q_a.push_back(2);
`endif
      step_a(1'b1, (i == 1 || i == 4) ? 1'b0 : 1'b1, 1'b0);
    end
    step_a(1'b0, 1'b0, 1'b0);
`ifdef SEQ_OVERLAP_EN
    chk("count after 1011011", int'(count_a), 2);
`else
    chk("count after 1011011", int'(count_a), 1);
`endif

    // Invalid cycles must leave the history untouched.
    pulse_reset();
    step_a(1'b1, 1'b1, 1'b0);
    step_a(1'b1, 1'b0, 1'b0);
    step_a(1'b0, 1'b1, 1'b0);
    step_a(1'b0, 1'b0, 1'b0);
    step_a(1'b0, 1'b1, 1'b0);
    chk("state held while invalid", int'(state_a), 1);
    step_a(1'b1, 1'b1, 1'b0);
    q_a.push_back(1);
    step_a(1'b1, 1'b1, 1'b0);
    step_a(1'b0, 1'b0, 1'b0);
    chk("count after gapped 1011", int'(count_a), 1);

    // Reset mid-pattern clears fill, so a following 1 does not complete 1011.
    pulse_reset();
    step_a(1'b1, 1'b1, 1'b0);
    step_a(1'b1, 1'b0, 1'b0);
    step_a(1'b1, 1'b1, 1'b0);
    pulse_reset();
    chk("state after mid reset", int'(state_a), 0);
    step_a(1'b1, 1'b1, 1'b0);
    step_a(1'b0, 1'b0, 1'b0);
    chk("count after reset bit", int'(count_a), 0);
    step_a(1'b1, 1'b0, 1'b0);
    step_a(1'b1, 1'b1, 1'b0);
    q_a.push_back(1);
    step_a(1'b1, 1'b1, 1'b0);
    // Second 1011 with CLR on its completing edge: MATCH pulses, COUNT goes to 0.
    step_a(1'b1, 1'b1, 1'b0);
    step_a(1'b1, 1'b0, 1'b0);
    step_a(1'b1, 1'b1, 1'b0);
    q_a.push_back(0);
    step_a(1'b1, 1'b1, 1'b1);
    step_a(1'b0, 1'b0, 1'b0);
    chk("count after clr on match", int'(count_a), 0);
    chk("sat after clr on match", int'(sat_a), 0);

    step_a(1'b0, 1'b0, 1'b0);
    while (q_a.size() != 0) begin
      void'(q_a.pop_front());
      chk("a missing match", 0, 1);
    end
    while (q_z.size() != 0) begin
      void'(q_z.pop_front());
      chk("z missing match", 0, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
